// File: rtl/wb_stream_writer.sv
// wb_stream_writer: Wishbone classic master that writes a valid/ready word stream to sequential addresses.
// Define WB_STREAM_WRITER_ERR_EN to add wb_err_i termination and the status_err flag.
module wb_stream_writer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_we_o,
    output logic [SELECT_WIDTH-1:0] wb_sel_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic                    wb_ack_i,
`ifdef WB_STREAM_WRITER_ERR_EN
    input  logic                    wb_err_i,
    output logic                    status_err,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    words_done
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(SELECT_WIDTH);
    localparam logic [LEN_WIDTH-1:0]  ONE  = LEN_WIDTH'(1);

    state_t               state, state_n;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 accept, take, ok, fail;

    assign accept = (state == IDLE) && cmd_valid;
    assign take   = (state == FETCH) && s_tvalid;

    // An error wins over a simultaneous ack: the beat is treated as not written.
`ifdef WB_STREAM_WRITER_ERR_EN
    assign fail = (state == WRITE) && wb_err_i;
`else
    assign fail = 1'b0;
`endif
    assign ok = (state == WRITE) && wb_ack_i && !fail;

    assign cmd_ready = state == IDLE;
    assign s_tready  = state == FETCH;
    assign wb_cyc_o  = state == WRITE;
    assign wb_stb_o  = state == WRITE;
    assign wb_we_o   = state == WRITE;
    assign wb_sel_o  = (state == WRITE) ? '1 : '0;
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  state_n = cmd_valid ? ((cmd_len == '0) ? DONE : FETCH) : IDLE;
            FETCH: state_n = s_tvalid ? WRITE : FETCH;
            WRITE: state_n = fail ? DONE : ok ? ((words_done + ONE == len_q) ? DONE : FETCH) : WRITE;
            DONE:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            words_done <= '0;
            len_q      <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                wb_adr_o   <= cmd_addr & ~(STEP - ONE[0 +: 1]);
                len_q      <= cmd_len;
                words_done <= '0;
            end
            if (take)
                wb_dat_o <= s_tdata;
            if (ok) begin
                words_done <= words_done + ONE;
                wb_adr_o   <= wb_adr_o + STEP;
            end
        end
    end

`ifdef WB_STREAM_WRITER_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            status_err <= 1'b0;
        else if (accept)
            status_err <= 1'b0;
        else if (fail)
            status_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_wb_stream_writer.sv
// tb_wb_stream_writer: scoreboard bench for wb_stream_writer with a registered-ack Wishbone slave.
// Define WB_STREAM_WRITER_ERR_EN to also exercise the error-termination path.
module tb_wb_stream_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        sl_err = 1'b0;
    logic        err_arm = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] words_done;
`ifdef WB_STREAM_WRITER_ERR_EN
    logic        status_err;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          bus_viol = 0;
    int          unstable = 0;
    int          done_cnt = 0;
    int          d0;
    int          n;
    logic [63:0] sb[$];
    logic [63:0] hold = '0;
    logic        prev_ack = 1'b0;
    logic        prev_stb = 1'b0;

    wb_stream_writer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i),
`ifdef WB_STREAM_WRITER_ERR_EN
        .wb_err_i   (sl_err),
        .status_err (status_err),
`endif
        .busy       (busy),
        .done       (done),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    // Slave registers its response and only re-arms once the previous one has dropped; it is never reset,
    // so a beat in flight at reset produces a stale ack afterwards.
    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && !wb_ack_i && !sl_err) begin
            wb_ack_i <= !err_arm;
            sl_err   <= err_arm;
        end else begin
            wb_ack_i <= 1'b0;
            sl_err   <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wb_cyc_o && wb_stb_o && wb_ack_i) begin
            logic [63:0] e;
            e = (sb.size() != 0) ? sb.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
            check("wr_adr", {32'b0, wb_adr_o}, {32'b0, e[63:32]});
            check("wr_dat", {32'b0, wb_dat_o}, {32'b0, e[31:0]});
            check("wr_sel", {60'b0, wb_sel_o}, 64'hF);
            check("wr_we", {63'b0, wb_we_o}, 64'h1);
        end
        if (prev_ack && wb_stb_o) bus_viol <= bus_viol + 1;
        if (wb_stb_o && prev_stb && {wb_adr_o, wb_dat_o} != hold) unstable <= unstable + 1;
        if (wb_stb_o && !prev_stb) hold <= {wb_adr_o, wb_dat_o};
        prev_ack <= wb_ack_i;
        prev_stb <= wb_stb_o;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_rst();
        check("rst_cmd_ready", {63'b0, cmd_ready}, 64'h1);
        check("rst_s_tready", {63'b0, s_tready}, 64'h0);
        check("rst_cyc_stb_we", {61'b0, wb_cyc_o, wb_stb_o, wb_we_o}, 64'h0);
        check("rst_sel", {60'b0, wb_sel_o}, 64'h0);
        check("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'h0);
        check("rst_busy_done", {62'b0, busy, done}, 64'h0);
        check("rst_words_done", {48'b0, words_done}, 64'h0);
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] l);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        check("cmd_ready", {63'b0, cmd_ready}, 64'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d, input logic [31:0] a, input int gap, input bit push);
        int k = 0;
        while (!s_tready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("fetch_timeout", {63'b0, k < 100}, 64'h1);
        repeat (gap) begin
            check("gap_cyc", {62'b0, wb_cyc_o, wb_stb_o}, 64'h0);
            @(negedge clk);
        end
        if (push) sb.push_back({a, d});
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", {63'b0, k < 200}, 64'h1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; s_tvalid = 1'b0; s_tdata = '0;
        repeat (3) @(negedge clk);
        check_rst();
        rst = 1'b0;

        d0 = done_cnt;
        sb.push_back({32'h100, 32'h11});
        s_tdata  = 32'h11;
        s_tvalid = 1'b1;
        send_cmd(32'h100, 16'd4);
        check("lat_fetch", {62'b0, s_tready, wb_stb_o}, 64'h2);
        @(negedge clk);
        s_tvalid = 1'b0;
        check("lat_stb", {63'b0, wb_stb_o}, 64'h1);
        feed(32'h22, 32'h104, 0, 1);
        feed(32'h33, 32'h108, 0, 1);
        feed(32'h44, 32'h10C, 0, 1);
        wait_done();
        check("t1_words_done", {48'b0, words_done}, 64'd4);
        @(negedge clk);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("t1_sb_empty", 64'(sb.size()), 64'd0);

        send_cmd(32'h500, 16'd0);
        check("len0_done_busy", {62'b0, done, busy}, 64'h3);
        check("len0_idle_bus", {62'b0, s_tready, wb_cyc_o}, 64'h0);
        check("len0_words", {48'b0, words_done}, 64'd0);
        @(negedge clk);
        check("len0_after", {62'b0, done, cmd_ready}, 64'h1);

        send_cmd(32'h103, 16'd2);
        feed(32'hA1, 32'h100, 5, 1);
        feed(32'hA2, 32'h104, 5, 1);
        wait_done();
        check("t3_words_done", {48'b0, words_done}, 64'd2);

        send_cmd(32'hFFFF_FFFC, 16'd2);
        feed(32'hB1, 32'hFFFF_FFFC, 0, 1);
        feed(32'hB2, 32'h0, 0, 1);
        wait_done();
        check("wrap_words_done", {48'b0, words_done}, 64'd2);

        send_cmd(32'h1000, 16'd8);
        feed(32'hC1, 32'h1000, 0, 1);
        feed(32'hC2, 32'h1004, 0, 1);
        feed(32'hC3, 32'h1008, 0, 0);
        check("t5_stb_word3", {63'b0, wb_stb_o}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_rst();
        send_cmd(32'h40, 16'd1);
        feed(32'hD1, 32'h40, 0, 1);
        wait_done();
        check("t5_words_done", {48'b0, words_done}, 64'd1);
        check("t5_sb_empty", 64'(sb.size()), 64'd0);

`ifdef WB_STREAM_WRITER_ERR_EN
        send_cmd(32'h200, 16'd4);
        feed(32'hE1, 32'h200, 0, 1);
        n = 0;
        while (words_done != 16'd1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        err_arm = 1'b1;
        feed(32'hE2, 32'h204, 0, 0);
        wait_done();
        err_arm = 1'b0;
        check("err_status", {63'b0, status_err}, 64'h1);
        check("err_words_done", {48'b0, words_done}, 64'd1);
        s_tvalid = 1'b1;
        repeat (5) begin
            check("err_no_consume", {63'b0, s_tready}, 64'h0);
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        send_cmd(32'h300, 16'd0);
        check("err_clear", {63'b0, status_err}, 64'h0);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        check("bus_rule", 64'(bus_viol), 64'd0);
        check("stb_stable", 64'(unstable), 64'd0);
        check("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
